uart_transmitter: RTL

Transmit half of the UART link. It accepts parallel words through a small FIFO with a valid/ready handshake and serialises each word onto `txd` as: start bit, LSB-first data, optional even parity, stop bits. Baud timing comes from a code-controlled NCO and a 16× oversampling tick, the same scheme the receive side uses, so both ends derive bit periods identically. It sits between the command/response logic and the pad driver.

---
 rtl/uart_transmitter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// UART transmit path: valid/ready FIFO feeding a start/data/parity/stop serialiser,
// with bit timing from a 17-bit NCO and a 16x oversampling tick.
module uart_transmitter #(
  parameter int EIGHT_BIT_DATA = 8,
  parameter int PARITY_BIT     = 0,
  parameter int STOP_BIT       = 2,
  parameter int DEFAULT_BDR    = 115200,
  parameter int SYS_CLK_DIV2   = 100_000_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [EIGHT_BIT_DATA-1:0] data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      txd,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam longint unsigned NCO_FULL =
    (64'd16 * 64'(DEFAULT_BDR) * 64'd65536) / 64'(SYS_CLK_DIV2);
  localparam logic [16:0] NCO_INC = NCO_FULL[16:0];

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_BIT   = 3'd1,
    SEND_DATA   = 3'd2,
    SEND_PARITY = 3'd3,
    SEND_STOP   = 3'd4,
    DONE        = 3'd5
  } state_t;

  function automatic logic parity_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

  logic [16:0]               acc_r;
  logic                      acc_msb_d_r;
  logic                      tick_r;
  logic [3:0]                tick_cnt_r;
  logic [EIGHT_BIT_DATA-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]               wptr_r;
  logic [AW:0]               rptr_r;
  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [EIGHT_BIT_DATA-1:0] shift_r;
  logic [EIGHT_BIT_DATA-1:0] shift_nxt_s;
  logic                      par_r;
  logic                      par_nxt_s;
  logic [3:0]                bit_cnt_r;
  logic [3:0]                bit_cnt_nxt_s;
  logic [1:0]                stop_cnt_r;
  logic [1:0]                stop_cnt_nxt_s;
  logic                      txd_r;
  logic                      txd_nxt_s;
  logic                      done_r;
  logic                      full_s;
  logic                      empty_s;
  logic                      pop_s;
  logic                      push_s;
  logic                      boundary_s;

  assign empty_s    = (wptr_r == rptr_r);
  assign full_s     = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign pop_s      = (state_r == IDLE) && tick_r && !empty_s;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a word then.
  assign ready      = !full_s || pop_s;
  assign push_s     = valid && ready;
  assign boundary_s = tick_r && (tick_cnt_r == 4'd15);

  assign txd  = txd_r;
  assign done = done_r;
  assign busy = (state_r != IDLE) || !empty_s;

  // NCO accumulator and registered rising-edge detect of its MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= 17'h10000;
      acc_msb_d_r <= 1'b1;
      tick_r      <= 1'b0;
    end else begin
      acc_r       <= acc_r + NCO_INC;
      acc_msb_d_r <= acc_r[16];
      tick_r      <= acc_r[16] && !acc_msb_d_r;
    end
  end

  // Oversampling counter, parked at zero while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= 4'd0;
    end else if (state_r == IDLE) begin
      tick_cnt_r <= 4'd0;
    end else if (tick_r) begin
      tick_cnt_r <= tick_cnt_r + 4'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + (AW+1)'(1);
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r[AW-1:0]] <= data;
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      par_r      <= 1'b0;
      bit_cnt_r  <= 4'd0;
      stop_cnt_r <= 2'd0;
      txd_r      <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      shift_r    <= shift_nxt_s;
      par_r      <= par_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      stop_cnt_r <= stop_cnt_nxt_s;
      txd_r      <= txd_nxt_s;
      done_r     <= (state_nxt_s == DONE);
    end
  end

  // Next-state and datapath updates; all transitions except IDLE/DONE happen on bit boundaries
  always_comb begin
    state_nxt_s    = state_r;
    shift_nxt_s    = shift_r;
    par_nxt_s      = par_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    stop_cnt_nxt_s = stop_cnt_r;
    case (state_r)
      IDLE: begin
        if (pop_s) begin
          shift_nxt_s    = mem_r[rptr_r[AW-1:0]];
          par_nxt_s      = 1'b0;
          bit_cnt_nxt_s  = 4'd0;
          stop_cnt_nxt_s = 2'd0;
          state_nxt_s    = START_BIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START_BIT: begin
        if (boundary_s) begin
          state_nxt_s = SEND_DATA;
        end else begin
          state_nxt_s = START_BIT;
        end
      end
      SEND_DATA: begin
        if (boundary_s) begin
          shift_nxt_s   = shift_r >> 1;
          par_nxt_s     = parity_step(par_r, shift_r[0]);
          bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'(EIGHT_BIT_DATA-1)) begin
            state_nxt_s = (PARITY_BIT != 0) ? SEND_PARITY : SEND_STOP;
          end else begin
            state_nxt_s = SEND_DATA;
          end
        end else begin
          state_nxt_s = SEND_DATA;
        end
      end
      SEND_PARITY: begin
        if (boundary_s) begin
          state_nxt_s = SEND_STOP;
        end else begin
          state_nxt_s = SEND_PARITY;
        end
      end
      SEND_STOP: begin
        if (boundary_s) begin
          if (stop_cnt_r == 2'(STOP_BIT-1)) begin
            state_nxt_s = DONE;
          end else begin
            stop_cnt_nxt_s = stop_cnt_r + 2'd1;
            state_nxt_s    = SEND_STOP;
          end
        end else begin
          state_nxt_s = SEND_STOP;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Line level for the upcoming cycle, so txd comes straight from a flop
  always_comb begin
    txd_nxt_s = 1'b1;
    case (state_nxt_s)
      START_BIT:   txd_nxt_s = 1'b0;
      SEND_DATA:   txd_nxt_s = shift_nxt_s[0];
      SEND_PARITY: txd_nxt_s = par_nxt_s;
      IDLE:        txd_nxt_s = 1'b1;
      SEND_STOP:   txd_nxt_s = 1'b1;
      DONE:        txd_nxt_s = 1'b1;
      default:     txd_nxt_s = 1'b1;
    endcase
  end

endmodule
